// File: rtl/mode_switcher_pkg.sv
// Shared types and defaults for the mode switcher: FSM states, source mode
// encodings, parameter defaults and the packing of per-mode control bits.
package mode_switcher_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StQuiesce = 2'd1,
    StGuard   = 2'd2,
    StReload  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ModeAcq      = 2'd0,
    ModeScurve   = 2'd1,
    ModeSweepAcq = 2'd2
  } mode_e;

  localparam int unsigned DefNumModes       = 4;
  localparam int unsigned DefModeBits       = 2;
  localparam int unsigned DefNumDac         = 3;
  localparam int unsigned DefDacWidth       = 10;
  localparam int unsigned DefDataWidth      = 16;
  localparam int unsigned DefGuardCycles    = 8;
  localparam int unsigned DefQuiesceTimeout = 1024;

  // Per-mode control bits are packed into one slice so a single mux selects them.
  localparam int unsigned CtrlW      = 5;
  localparam int unsigned CtrlSCLoad = 4;
  localparam int unsigned CtrlStart  = 3;
  localparam int unsigned CtrlBusy   = 2;
  localparam int unsigned CtrlDone   = 1;
  localparam int unsigned CtrlDataEn = 0;

endpackage

// File: rtl/mode_switcher_if.sv
// Bundle of the per-mode source buses and the switched outputs.
// master: the mode sources / environment; slave: the switcher.
interface mode_switcher_if
  import mode_switcher_pkg::*;
#(
  parameter int unsigned NUM_MODES  = DefNumModes,
  parameter int unsigned MODE_BITS  = DefModeBits,
  parameter int unsigned NUM_DAC    = DefNumDac,
  parameter int unsigned DAC_WIDTH  = DefDacWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
);

  logic [MODE_BITS-1:0]                     ModeSelect;
  logic [NUM_MODES*NUM_DAC*DAC_WIDTH-1:0]   SrcDac;
  logic [NUM_MODES-1:0]                     SrcSCLoad;
  logic [NUM_MODES-1:0]                     SrcStartStop;
  logic [NUM_MODES-1:0]                     SrcBusy;
  logic [NUM_MODES-1:0]                     SrcDone;
  logic [NUM_MODES*DATA_WIDTH-1:0]          SrcData;
  logic [NUM_MODES-1:0]                     SrcData_en;

  logic [NUM_DAC*DAC_WIDTH-1:0]             OutDac;
  logic                                     OutSCParameterLoad;
  logic [NUM_MODES-1:0]                     OutStartStop;
  logic                                     SweepTestDone;
  logic [DATA_WIDTH-1:0]                    UsbFifoData;
  logic                                     UsbFifoData_en;
  logic [MODE_BITS-1:0]                     ActiveMode;
  logic                                     SwitchBusy;
  logic [15:0]                              DroppedCount;

  modport master (
    output ModeSelect, SrcDac, SrcSCLoad, SrcStartStop, SrcBusy, SrcDone, SrcData, SrcData_en,
    input  OutDac, OutSCParameterLoad, OutStartStop, SweepTestDone, UsbFifoData, UsbFifoData_en,
    input  ActiveMode, SwitchBusy, DroppedCount
  );

  modport slave (
    input  ModeSelect, SrcDac, SrcSCLoad, SrcStartStop, SrcBusy, SrcDone, SrcData, SrcData_en,
    output OutDac, OutSCParameterLoad, OutStartStop, SweepTestDone, UsbFifoData, UsbFifoData_en,
    output ActiveMode, SwitchBusy, DroppedCount
  );

endinterface

// File: rtl/switch_slice_mux.sv
// Selects one WIDTH-bit slice out of NUM_MODES packed slices; slice m sits at
// bits [m*WIDTH +: WIDTH]. An out-of-range select yields zero.
module switch_slice_mux #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned NUM_MODES = 4
) (
  input  logic [NUM_MODES*WIDTH-1:0] bus_i,
  input  logic [31:0]                sel_i,
  output logic [WIDTH-1:0]           slice_o
);

  // Plain indexed select written as a loop so any NUM_MODES works.
  always_comb begin
    slice_o = '0;
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      if (sel_i == m) slice_o = bus_i[m*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mode_switcher.sv
// Switches the SC DAC codes, control levels and USB data stream between source
// modes. A switch quiesces the old source, waits a guard interval, then issues a
// single parameter-load pulse with the new mode's DAC codes. All outputs are
// registered.
module mode_switcher
  import mode_switcher_pkg::*;
#(
  parameter int unsigned NUM_MODES       = DefNumModes,
  parameter int unsigned MODE_BITS       = DefModeBits,
  parameter int unsigned NUM_DAC         = DefNumDac,
  parameter int unsigned DAC_WIDTH       = DefDacWidth,
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned GUARD_CYCLES    = DefGuardCycles,
  parameter int unsigned QUIESCE_TIMEOUT = DefQuiesceTimeout
) (
  input logic            Clk,
  input logic            reset_n,
  mode_switcher_if.slave sw_io
);

  localparam int unsigned DacBusW = NUM_DAC * DAC_WIDTH;
  localparam int unsigned CntMax  = (QUIESCE_TIMEOUT > GUARD_CYCLES) ? QUIESCE_TIMEOUT
                                                                     : GUARD_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  state_e                state_q, state_d;
  logic [MODE_BITS-1:0]  active_q, active_d;
  logic [MODE_BITS-1:0]  tgt_q, tgt_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DacBusW-1:0]    dac_q, dac_d;
  logic                  load_q, load_d;
  logic [NUM_MODES-1:0]  ss_q, ss_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic [15:0]           drop_q, drop_d;

  logic [NUM_MODES*CtrlW-1:0] ctrl_bus;
  logic [CtrlW-1:0]           ctrl_act;
  logic [DacBusW-1:0]         dac_act, dac_tgt;
  logic [DATA_WIDTH-1:0]      data_act;
  logic                       sel_ok;

  for (genvar m = 0; m < NUM_MODES; m++) begin : g_ctrl
    assign ctrl_bus[m*CtrlW +: CtrlW] = {sw_io.SrcSCLoad[m], sw_io.SrcStartStop[m],
                                         sw_io.SrcBusy[m], sw_io.SrcDone[m],
                                         sw_io.SrcData_en[m]};
  end

  switch_slice_mux #(.WIDTH(DacBusW), .NUM_MODES(NUM_MODES)) u_dac_act (
    .bus_i  (sw_io.SrcDac),
    .sel_i  (32'(active_q)),
    .slice_o(dac_act)
  );

  // Second DAC select feeds the reload with the target's codes before ActiveMode updates.
  switch_slice_mux #(.WIDTH(DacBusW), .NUM_MODES(NUM_MODES)) u_dac_tgt (
    .bus_i  (sw_io.SrcDac),
    .sel_i  (32'(tgt_q)),
    .slice_o(dac_tgt)
  );

  switch_slice_mux #(.WIDTH(DATA_WIDTH), .NUM_MODES(NUM_MODES)) u_data (
    .bus_i  (sw_io.SrcData),
    .sel_i  (32'(active_q)),
    .slice_o(data_act)
  );

  switch_slice_mux #(.WIDTH(CtrlW), .NUM_MODES(NUM_MODES)) u_ctrl (
    .bus_i  (ctrl_bus),
    .sel_i  (32'(active_q)),
    .slice_o(ctrl_act)
  );

  // Next state and next registered outputs; pulses default low, buses hold.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    load_d   = 1'b0;
    ss_d     = '0;
    done_d   = 1'b0;
    data_d   = data_q;
    en_d     = 1'b0;
    drop_d   = drop_q;
    sel_ok   = 32'(sw_io.ModeSelect) < NUM_MODES;

    unique case (state_q)
      StRun: begin
        dac_d  = dac_act;
        load_d = ctrl_act[CtrlSCLoad];
        done_d = ctrl_act[CtrlDone];
        data_d = data_act;
        en_d   = ctrl_act[CtrlDataEn];
        for (int unsigned m = 0; m < NUM_MODES; m++) begin
          ss_d[m] = ctrl_act[CtrlStart] && (32'(active_q) == m);
        end
        if (sel_ok && (sw_io.ModeSelect != active_q)) begin
          tgt_d   = sw_io.ModeSelect;
          cnt_d   = '0;
          state_d = StQuiesce;
        end
      end
      StQuiesce: begin
        // Old mode keeps draining its data while the start level is withdrawn.
        dac_d  = dac_act;
        data_d = data_act;
        en_d   = ctrl_act[CtrlDataEn];
        if (sel_ok) tgt_d = sw_io.ModeSelect;
        if (tgt_d == active_q) begin
          state_d = StRun;
        end else if (!ctrl_act[CtrlBusy] || (cnt_q == CntW'(QUIESCE_TIMEOUT - 1))) begin
          cnt_d   = CntW'(GUARD_CYCLES - 1);
          state_d = StGuard;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGuard: begin
        if ((|sw_io.SrcData_en) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        if (cnt_q == '0) begin
          // Pulse is raised here so it lines up with the RELOAD state.
          active_d = tgt_q;
          load_d   = 1'b1;
          dac_d    = dac_tgt;
          state_d  = StReload;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StReload: begin
        if ((|sw_io.SrcData_en) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        dac_d   = dac_act;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    busy_d = (state_d != StRun);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q  <= StRun;
      active_q <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      dac_q    <= '0;
      load_q   <= 1'b0;
      ss_q     <= '0;
      done_q   <= 1'b0;
      data_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      dac_q    <= dac_d;
      load_q   <= load_d;
      ss_q     <= ss_d;
      done_q   <= done_d;
      data_q   <= data_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign sw_io.OutDac             = dac_q;
  assign sw_io.OutSCParameterLoad = load_q;
  assign sw_io.OutStartStop       = ss_q;
  assign sw_io.SweepTestDone      = done_q;
  assign sw_io.UsbFifoData        = data_q;
  assign sw_io.UsbFifoData_en     = en_q;
  assign sw_io.ActiveMode         = active_q;
  assign sw_io.SwitchBusy         = busy_q;
  assign sw_io.DroppedCount       = drop_q;

endmodule
